// File: rtl/alu_requester_if.sv
// alu_requester_if: upstream command and downstream response handshakes
// of the ALU requester, grouped into one bundle.
// master = the side that issues commands and consumes responses.
// slave  = alu_requester itself.
interface alu_requester_if #(
  parameter int WIDTH = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_requester.sv
// alu_requester: issue side of the registered add/sub ALU.
// Commands are issued to the ALU only while a result FIFO slot is reserved
// for them (credit = outstanding < DEPTH), because the ALU cannot be stalled.
// Results are collected into a registered FIFO and returned in issue order.
// Optional self-check: define ALU_REQ_CHECK_EN to build an expected-result
// queue and flag any ALU result that differs (sticky o_mismatch).
module alu_requester #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  alu_requester_if.slave             io_bus,
  output logic [1:0]                 o_alu_op,
  output logic [WIDTH-1:0]           o_alu_a,
  output logic [WIDTH-1:0]           o_alu_b,
  output logic                       o_alu_valid,
  input  logic [WIDTH-1:0]           i_alu_res,
  input  logic                       i_alu_res_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_outstanding,
  output logic                       o_overflow,
  output logic                       o_mismatch
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  logic [1:0]       r_alu_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_alu_valid;
  logic [CW-1:0]    r_outstanding;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_overflow;

  // Credits are held while in reset so nothing is accepted then.
  assign w_cmd_ready  = !i_rst && (r_outstanding < DEPTH_C);
  assign w_accept     = io_bus.cmd_valid && w_cmd_ready;
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == DEPTH_C);
  assign w_pop        = !w_fifo_empty && io_bus.rsp_ready;
  // A pop in the same cycle frees the slot for a push onto a full FIFO.
  assign w_push_ok    = i_alu_res_valid && (!w_fifo_full || w_pop);

  assign io_bus.cmd_ready = w_cmd_ready;
  assign io_bus.rsp_valid = !w_fifo_empty;
  assign io_bus.rsp_data  = r_mem[r_rptr];

  assign o_alu_op      = r_alu_op;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_valid   = r_alu_valid;
  assign o_outstanding = r_outstanding;
  assign o_overflow    = r_overflow;

  // Issue register: load the ALU inputs on accept, otherwise idle as a nop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alu_valid <= 1'b0;
      r_alu_op    <= OP_NOP;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
    end else if (w_accept) begin
      r_alu_valid <= 1'b1;
      r_alu_op    <= (io_bus.cmd_op == OP_RSV) ? OP_NOP : io_bus.cmd_op;
      r_alu_a     <= io_bus.cmd_a;
      r_alu_b     <= io_bus.cmd_b;
    end else begin
      r_alu_valid <= 1'b0;
      r_alu_op    <= OP_NOP;
    end
  end

  // Credit counter: +1 per accept, -1 per response pop, saturating at 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_outstanding <= '0;
    end else if (w_accept && !w_pop) begin
      r_outstanding <= r_outstanding + CW'(1);
    end else if (!w_accept && w_pop && (r_outstanding != '0)) begin
      r_outstanding <= r_outstanding - CW'(1);
    end
  end

  // Result FIFO; storage is cleared on reset so rsp_data reads 0 afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_alu_res;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_alu_res_valid && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef ALU_REQ_CHECK_EN
  logic [WIDTH-1:0] r_exp_mem [DEPTH];
  logic [AW-1:0]    r_exp_wptr;
  logic [AW-1:0]    r_exp_rptr;
  logic [CW-1:0]    r_exp_count;
  logic [WIDTH-1:0] w_exp_value;
  logic             w_exp_empty;
  logic             w_exp_push;
  logic             w_exp_pop;
  logic             r_mismatch;

  // Result the ALU should return for the command offered this cycle.
  always_comb begin
    w_exp_value = '0;
    case (io_bus.cmd_op)
      OP_ADD:  w_exp_value = io_bus.cmd_a + io_bus.cmd_b;
      OP_SUB:  w_exp_value = io_bus.cmd_a - io_bus.cmd_b;
      default: w_exp_value = '0;
    endcase
  end

  assign w_exp_empty = (r_exp_count == '0);
  assign w_exp_pop   = i_alu_res_valid && !w_exp_empty;
  assign w_exp_push  = w_accept && ((r_exp_count != DEPTH_C) || w_exp_pop);

  // Expected queue in issue order; each ALU result is compared to its head.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_exp_wptr  <= '0;
      r_exp_rptr  <= '0;
      r_exp_count <= '0;
      r_mismatch  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_exp_mem[i] <= '0;
      end
    end else begin
      if (w_exp_push) begin
        r_exp_mem[r_exp_wptr] <= w_exp_value;
        r_exp_wptr            <= r_exp_wptr + AW'(1);
      end
      if (w_exp_pop) begin
        r_exp_rptr <= r_exp_rptr + AW'(1);
      end
      case ({w_exp_push, w_exp_pop})
        2'b10:   r_exp_count <= r_exp_count + CW'(1);
        2'b01:   r_exp_count <= r_exp_count - CW'(1);
        default: r_exp_count <= r_exp_count;
      endcase
      if (i_alu_res_valid && (w_exp_empty || (r_exp_mem[r_exp_rptr] != i_alu_res))) begin
        r_mismatch <= 1'b1;
      end
    end
  end

  assign o_mismatch = r_mismatch;
`else
  assign o_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_requester.sv
// tb_alu_requester: directed bench for alu_requester (WIDTH=6, DEPTH=4)
// with a one-cycle registered add/sub ALU model that can be made faulty.
module tb_alu_requester;
  localparam int WIDTH = 6;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_requester_if #(.WIDTH(WIDTH)) bus ();

  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic             alu_valid, alu_res_valid;
  logic [CW-1:0]    outstanding;
  logic             overflow, mismatch;
  logic             alu_bug = 1'b0;

  int checks = 0;
  int errors = 0;

  alu_requester #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .io_bus(bus),
    .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_valid(alu_valid),
    .i_alu_res(alu_res), .i_alu_res_valid(alu_res_valid),
    .o_outstanding(outstanding), .o_overflow(overflow), .o_mismatch(mismatch)
  );

  // ALU model: registered, one cycle latency; alu_bug adds 1 to add results.
  always @(posedge clk) begin
    if (rst) begin
      alu_res_valid <= 1'b0;
      alu_res       <= '0;
    end else begin
      alu_res_valid <= alu_valid;
      case (alu_op)
        2'd1:    alu_res <= alu_a + alu_b + {{(WIDTH-1){1'b0}}, alu_bug};
        2'd2:    alu_res <= alu_a - alu_b;
        default: alu_res <= '0;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %0d want 0", bus.cmd_ready); end
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_alu_valid got %0d want 0", alu_valid); end
    checks++; if (outstanding !== 0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0d want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 0) begin errors++; $display("FAIL reset_rsp_data got %0d want 0", bus.rsp_data); end
    checks++; if (overflow !== 1'b0 || mismatch !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%0d mm=%0d want 0 0", overflow, mismatch); end
    rst = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cmd_ready got %0d want 1", bus.cmd_ready); end
    tick();
  endtask

  task automatic test_single_add();
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_a = 6'd5; bus.cmd_b = 6'd7;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL add_cmd_ready got %0d want 1", bus.cmd_ready); end
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if (alu_valid !== 1'b1 || alu_op !== 2'd1) begin errors++; $display("FAIL add_issue got valid=%0d op=%0d want 1 1", alu_valid, alu_op); end
    checks++; if (alu_a !== 6'd5 || alu_b !== 6'd7) begin errors++; $display("FAIL add_operands got %0d,%0d want 5,7", alu_a, alu_b); end
    checks++; if (outstanding !== 1) begin errors++; $display("FAIL add_outstanding1 got %0d want 1", outstanding); end
    tick();
    checks++; if (alu_valid !== 1'b0 || alu_op !== 2'd0 || alu_a !== 6'd5) begin errors++; $display("FAIL add_idle got valid=%0d op=%0d a=%0d want 0 0 5", alu_valid, alu_op, alu_a); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early_rsp got %0d want 0", bus.rsp_valid); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 6'd12) begin errors++; $display("FAIL add_rsp got valid=%0d data=%0d want 1 12", bus.rsp_valid, bus.rsp_data); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || outstanding !== 0) begin errors++; $display("FAIL add_drained got valid=%0d outst=%0d want 0 0", bus.rsp_valid, outstanding); end
  endtask

  task automatic test_back_to_back();
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_a = 6'd3; bus.cmd_b = 6'd5;
    tick();
    bus.cmd_a = 6'd0; bus.cmd_b = 6'd1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 6'd62) begin errors++; $display("FAIL b2b_first got valid=%0d data=%0d want 1 62", bus.rsp_valid, bus.rsp_data); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 6'd63) begin errors++; $display("FAIL b2b_second got valid=%0d data=%0d want 1 63", bus.rsp_valid, bus.rsp_data); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || outstanding !== 0) begin errors++; $display("FAIL b2b_drained got valid=%0d outst=%0d want 0 0", bus.rsp_valid, outstanding); end
  endtask

  task automatic test_credit_stall();
    int accepts = 0;
    int got = 0;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_b = 6'd1;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_a = WIDTH'(10 + accepts);
      if (bus.cmd_ready) accepts++;
      tick();
    end
    repeat (2) tick();
    checks++; if (accepts !== 4) begin errors++; $display("FAIL stall_accepts got %0d want 4", accepts); end
    checks++; if (bus.cmd_ready !== 1'b0 || outstanding !== 4) begin errors++; $display("FAIL stall_full got ready=%0d outst=%0d want 0 4", bus.cmd_ready, outstanding); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 6'd11) begin errors++; $display("FAIL stall_head got valid=%0d data=%0d want 1 11", bus.rsp_valid, bus.rsp_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stall_overflow got %0d want 0", overflow); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++; if (bus.cmd_ready !== 1'b1 || outstanding !== 3 || bus.rsp_data !== 6'd12) begin errors++; $display("FAIL pulse_pop got ready=%0d outst=%0d data=%0d want 1 3 12", bus.cmd_ready, outstanding, bus.rsp_data); end
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if (outstanding !== 4 || alu_valid !== 1'b1 || alu_a !== 6'd14 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL pulse_accept got outst=%0d valid=%0d a=%0d ready=%0d want 4 1 14 0", outstanding, alu_valid, alu_a, bus.cmd_ready); end
    bus.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      if (bus.rsp_valid) begin
        checks++; if (bus.rsp_data !== WIDTH'(12 + got)) begin errors++; $display("FAIL stall_drain got %0d want %0d", bus.rsp_data, 12 + got); end
        got++;
      end
      tick();
    end
    checks++; if (got !== 4 || outstanding !== 0) begin errors++; $display("FAIL stall_drain_count got n=%0d outst=%0d want 4 0", got, outstanding); end
  endtask

  task automatic test_concurrent();
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] e;
    int got = 0;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1;
    for (int k = 0; k < 3; k++) begin
      bus.cmd_a = WIDTH'(20 + k); bus.cmd_b = WIDTH'(k);
      exp_q.push_back(WIDTH'(20 + 2 * k));
      tick();
    end
    bus.cmd_valid = 1'b0;
    repeat (3) tick();
    checks++; if (outstanding !== 3 || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL conc_setup got outst=%0d valid=%0d want 3 1", outstanding, bus.rsp_valid); end
    for (int n = 0; n < 20; n++) begin
      bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b1;
      bus.cmd_op = 2'($urandom_range(0, 3));
      bus.cmd_a = WIDTH'($urandom); bus.cmd_b = WIDTH'($urandom);
      case (bus.cmd_op)
        2'd1:    e = bus.cmd_a + bus.cmd_b;
        2'd2:    e = bus.cmd_a - bus.cmd_b;
        default: e = '0;
      endcase
      checks++; if (outstanding !== 3 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL conc_credit n=%0d got outst=%0d ready=%0d want 3 1", n, outstanding, bus.cmd_ready); end
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_q[0]) begin errors++; $display("FAIL conc_order n=%0d got valid=%0d data=%0d want 1 %0d", n, bus.rsp_valid, bus.rsp_data, exp_q[0]); end
      void'(exp_q.pop_front());
      exp_q.push_back(e);
      tick();
    end
    bus.cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      if (bus.rsp_valid) begin
        checks++; if (bus.rsp_data !== exp_q[0]) begin errors++; $display("FAIL conc_drain got %0d want %0d", bus.rsp_data, exp_q[0]); end
        void'(exp_q.pop_front());
        got++;
      end
      tick();
    end
    checks++; if (got !== 3 || outstanding !== 0 || mismatch !== 1'b0) begin errors++; $display("FAIL conc_end got n=%0d outst=%0d mm=%0d want 3 0 0", got, outstanding, mismatch); end
  endtask

  task automatic test_reset_midop();
    int stale = 0;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_b = 6'd1;
    for (int k = 1; k <= 3; k++) begin
      bus.cmd_a = WIDTH'(k);
      tick();
    end
    bus.cmd_valid = 1'b0;
    tick();
    checks++; if (outstanding !== 3 || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL midop_pre got outst=%0d valid=%0d want 3 1", outstanding, bus.rsp_valid); end
    rst = 1'b1;
    tick();
    checks++; if (alu_valid !== 0 || alu_op !== 0 || alu_a !== 0 || alu_b !== 0) begin errors++; $display("FAIL midop_alu got v=%0d op=%0d a=%0d b=%0d want 0 0 0 0", alu_valid, alu_op, alu_a, alu_b); end
    checks++; if (bus.rsp_valid !== 0 || bus.rsp_data !== 0 || outstanding !== 0) begin errors++; $display("FAIL midop_rsp got v=%0d d=%0d outst=%0d want 0 0 0", bus.rsp_valid, bus.rsp_data, outstanding); end
    checks++; if (overflow !== 0 || mismatch !== 0 || bus.cmd_ready !== 0) begin errors++; $display("FAIL midop_flags got ovf=%0d mm=%0d ready=%0d want 0 0 0", overflow, mismatch, bus.cmd_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midop_ready got %0d want 1", bus.cmd_ready); end
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (bus.rsp_valid !== 1'b0) stale++;
      tick();
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL midop_stale got %0d stale cycles want 0", stale); end
  endtask

  task automatic test_mismatch();
    logic exp_mm;
`ifdef ALU_REQ_CHECK_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif
    alu_bug = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_a = 6'd5; bus.cmd_b = 6'd7;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (2) tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 6'd13) begin errors++; $display("FAIL mm_rsp got valid=%0d data=%0d want 1 13", bus.rsp_valid, bus.rsp_data); end
    tick();
    checks++; if (mismatch !== exp_mm) begin errors++; $display("FAIL mm_set got %0d want %0d", mismatch, exp_mm); end
    repeat (3) tick();
    checks++; if (mismatch !== exp_mm) begin errors++; $display("FAIL mm_sticky got %0d want %0d", mismatch, exp_mm); end
    alu_bug = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mm_clear got %0d want 0", mismatch); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_add();
    test_back_to_back();
    test_credit_stall();
    test_concurrent();
    test_reset_midop();
    test_mismatch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
